// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One radix-2 step per cycle; stalls the pipeline until the registered result is ready.
module ex_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned CW = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                valid_q, valid_d;

    logic                a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum, rem_sh;
    logic [XLEN-1:0]     rem_new;
    logic                ge;
    logic [2*XLEN-1:0]   step, mul_fix;
    logic [XLEN-1:0]     div_sel, fin;

    // Operand magnitudes: a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM.
    always_comb begin
        a_neg = src_a_i[XLEN-1] & ((funct3_i == 3'd1) | (funct3_i == 3'd2) |
                                   (funct3_i == 3'd4) | (funct3_i == 3'd6));
        b_neg = src_b_i[XLEN-1] & ((funct3_i == 3'd1) | (funct3_i == 3'd4) |
                                   (funct3_i == 3'd6));
        a_mag = a_neg ? (~src_a_i + 1'b1) : src_a_i;
        b_mag = b_neg ? (~src_b_i + 1'b1) : src_b_i;
        div0  = (src_b_i == '0);
        ovf   = ~funct3_i[0] & (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&src_b_i);
    end

    // acc holds {high product, multiplier} for multiply, {remainder, quotient} for divide.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        ge      = (rem_sh >= {1'b0, b_q});
        rem_new = ge ? XLEN'(rem_sh - {1'b0, b_q}) : rem_sh[XLEN-1:0];
        step    = f3_q[2] ? {rem_new, acc_q[XLEN-2:0], ge}
                          : {mul_sum, acc_q[XLEN-1:1]};
        mul_fix = neg_q ? (~step + 1'b1) : step;
        div_sel = f3_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        if (f3_q[2])
            fin = neg_q ? (~div_sel + 1'b1) : div_sel;
        else
            fin = (f3_q[1:0] == 2'd0) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        res_d   = res_q;
        valid_d = 1'b0;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    f3_d  = funct3_i;
                    a_d   = a_mag;
                    b_d   = b_mag;
                    acc_d = {{XLEN{1'b0}}, funct3_i[2] ? a_mag : b_mag};
                    neg_d = (funct3_i[2] & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
                    if (funct3_i[2] & div0) begin
                        res_d   = funct3_i[1] ? src_a_i : '1;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else if (funct3_i[2] & ovf) begin
                        res_d   = funct3_i[1] ? '0 : src_a_i;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = CW'(XLEN);
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_d = step;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        res_d   = fin;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign stall_o  = start_i & (state_q != S_DONE) & ~flush_i;
    assign valid_o  = valid_q;
    assign result_o = res_q;
endmodule
